// File: rtl/bayer_mosaicing_pkg.sv
// Shared types and helpers for the Bayer mosaicing block.
//   site_e       : CFA site carried by a pixel position
//   *_FIELD      : component slot index inside the packed RGB word (offset = slot * px width)
//   tdata_width  : rounds a bit width up to a whole number of bytes
package bayer_pkg;

    typedef enum logic [1:0] {
        SITE_R  = 2'd0,
        SITE_GR = 2'd1,
        SITE_GB = 2'd2,
        SITE_B  = 2'd3
    } site_e;

    localparam int unsigned G_FIELD = 0;
    localparam int unsigned B_FIELD = 1;
    localparam int unsigned R_FIELD = 2;

    function automatic int unsigned tdata_width(input int unsigned px_w);
        return ((px_w + 32'd7) / 32'd8) * 32'd8;
    endfunction

endpackage

// File: rtl/bayer_mosaicing_if.sv
// AXI4-Stream bundle used for both the RGB sink and the raw Bayer source.
//   master : drives payload/valid, receives tready
//   slave  : receives payload/valid, drives tready
interface axi4_stream_if #(
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tid;
    logic              tdest;

    modport master (
        output tdata, tvalid, tlast, tuser, tkeep, tstrb, tid, tdest,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tuser, tkeep, tstrb, tid, tdest,
        output tready
    );

endinterface

// File: rtl/bayer_mosaicing_phase_tracker.sv
// Pixel/line phase tracking and frame geometry monitoring.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   beat_acc_i            : an input beat is accepted this cycle
//   tuser_i, tlast_i      : sideband of the beat being presented
//   first_px_is_odd_i     : pixel phase of the first pixel of each line
//   first_line_is_odd_i   : line phase of the first line of a frame
//   clr_err_i             : clears the sticky error flags
//   site_c                : CFA site of the beat being presented (combinational)
//   line_len_o            : first-line length of the last completed frame
//   frame_lines_o         : line count of the last completed frame
//   err_line_len_o        : sticky line-length mismatch flag
//   err_sof_o             : sticky start-of-frame-mid-line flag
module bayer_phase_tracker
    import bayer_pkg::*;
#(
    parameter int unsigned MAX_LINE_SIZE = 1920,
    parameter int unsigned MAX_LINES     = 1080,
    localparam int unsigned PX_CNT_W     = $clog2(MAX_LINE_SIZE + 1),
    localparam int unsigned LN_CNT_W     = $clog2(MAX_LINES + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                beat_acc_i,
    input  logic                tuser_i,
    input  logic                tlast_i,
    input  logic                first_px_is_odd_i,
    input  logic                first_line_is_odd_i,
    input  logic                clr_err_i,
    output site_e               site_c,
    output logic [PX_CNT_W-1:0] line_len_o,
    output logic [LN_CNT_W-1:0] frame_lines_o,
    output logic                err_line_len_o,
    output logic                err_sof_o
);

    localparam logic [PX_CNT_W-1:0] PX_MAX = PX_CNT_W'(MAX_LINE_SIZE);
    localparam logic [LN_CNT_W-1:0] LN_MAX = LN_CNT_W'(MAX_LINES);

    // mid_line_q = 0 means the next beat starts a line (also true out of reset)
    logic                mid_line_q;
    logic                px_odd_q;
    logic                line_odd_q;
    logic [PX_CNT_W-1:0] px_cnt_q;
    logic [PX_CNT_W-1:0] ref_len_q;
    logic [PX_CNT_W-1:0] line_len_q;
    logic [LN_CNT_W-1:0] line_cnt_q;
    logic [LN_CNT_W-1:0] frame_lines_q;
    logic                err_line_q;
    logic                err_sof_q;

    logic                px_odd_c;
    logic                line_odd_c;
    logic [PX_CNT_W-1:0] px_base_c;
    logic [PX_CNT_W-1:0] px_next_c;
    logic [LN_CNT_W-1:0] ln_base_c;
    logic [LN_CNT_W-1:0] ln_next_c;

    // Effective phase of the presented beat, and counters as seen after a tuser restart
    always_comb begin
        px_odd_c   = !px_odd_q;
        line_odd_c = line_odd_q;
        site_c     = SITE_GR;
        if (tuser_i || !mid_line_q) begin
            px_odd_c = first_px_is_odd_i;
        end
        if (tuser_i) begin
            line_odd_c = first_line_is_odd_i;
        end
        unique case ({line_odd_c, px_odd_c})
            2'b00:   site_c = SITE_B;
            2'b01:   site_c = SITE_GB;
            2'b10:   site_c = SITE_GR;
            default: site_c = SITE_R;
        endcase

        px_base_c = tuser_i ? '0 : px_cnt_q;
        ln_base_c = tuser_i ? '0 : line_cnt_q;
        px_next_c = (px_base_c >= PX_MAX) ? px_base_c : px_base_c + PX_CNT_W'(1);
        ln_next_c = (ln_base_c >= LN_MAX) ? ln_base_c : ln_base_c + LN_CNT_W'(1);
    end

    // Phase, counters, geometry report and sticky flags; an error event overrides clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mid_line_q    <= 1'b0;
            px_odd_q      <= 1'b0;
            line_odd_q    <= 1'b0;
            px_cnt_q      <= '0;
            ref_len_q     <= '0;
            line_len_q    <= '0;
            line_cnt_q    <= '0;
            frame_lines_q <= '0;
            err_line_q    <= 1'b0;
            err_sof_q     <= 1'b0;
        end else begin
            if (clr_err_i) begin
                err_line_q <= 1'b0;
                err_sof_q  <= 1'b0;
            end
            if (beat_acc_i) begin
                mid_line_q <= !tlast_i;
                px_odd_q   <= px_odd_c;
                line_odd_q <= line_odd_c ^ tlast_i;
                if (tuser_i) begin
                    if (px_cnt_q != '0) begin
                        err_sof_q <= 1'b1;
                    end
                    if (line_cnt_q != '0) begin
                        frame_lines_q <= line_cnt_q;
                        line_len_q    <= ref_len_q;
                    end
                end
                if (tlast_i) begin
                    px_cnt_q   <= '0;
                    line_cnt_q <= ln_next_c;
                    if (ln_base_c == '0) begin
                        ref_len_q <= px_next_c;
                    end else if (px_next_c != ref_len_q) begin
                        err_line_q <= 1'b1;
                    end
                end else begin
                    px_cnt_q   <= px_next_c;
                    line_cnt_q <= ln_base_c;
                end
            end
        end
    end

    assign line_len_o     = line_len_q;
    assign frame_lines_o  = frame_lines_q;
    assign err_line_len_o = err_line_q;
    assign err_sof_o      = err_sof_q;

endmodule

// File: rtl/bayer_mosaicing.sv
// RGB AXI4-Stream to single-channel Bayer raw stream (inverse demosaic).
//   clk_i, rst_i          : clock, synchronous active-high reset
//   en_i                  : 1 = mosaic, 0 = pass the G component
//   first_px_is_odd_i     : pixel phase of the first pixel of each line
//   first_line_is_odd_i   : line phase of the first line of a frame
//   clr_err_i             : clears sticky error flags
//   rgb_video_i           : RGB sink, tdata = {pad, R, B, G}
//   raw_video_o           : raw Bayer source, one register stage
//   line_len_o            : first-line length of the last completed frame
//   frame_lines_o         : line count of the last completed frame
//   err_line_len_o        : sticky line-length mismatch
//   err_sof_o             : sticky tuser-mid-line
module bayer_mosaicing
    import bayer_pkg::*;
#(
    parameter int unsigned RAW_PX_WIDTH  = 10,
    parameter int unsigned MAX_LINE_SIZE = 1920,
    parameter int unsigned MAX_LINES     = 1080,
    localparam int unsigned PX_CNT_W     = $clog2(MAX_LINE_SIZE + 1),
    localparam int unsigned LN_CNT_W     = $clog2(MAX_LINES + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                first_px_is_odd_i,
    input  logic                first_line_is_odd_i,
    input  logic                clr_err_i,
    axi4_stream_if.slave        rgb_video_i,
    axi4_stream_if.master       raw_video_o,
    output logic [PX_CNT_W-1:0] line_len_o,
    output logic [LN_CNT_W-1:0] frame_lines_o,
    output logic                err_line_len_o,
    output logic                err_sof_o
);

    localparam int unsigned RGB_TDATA_WIDTH = tdata_width(3 * RAW_PX_WIDTH);
    localparam int unsigned RAW_TDATA_WIDTH = tdata_width(RAW_PX_WIDTH);
    localparam int unsigned G_OFS           = G_FIELD * RAW_PX_WIDTH;
    localparam int unsigned B_OFS           = B_FIELD * RAW_PX_WIDTH;
    localparam int unsigned R_OFS           = R_FIELD * RAW_PX_WIDTH;

    logic                       out_valid_q;
    logic                       out_last_q;
    logic                       out_user_q;
    logic [RAW_TDATA_WIDTH-1:0] out_data_q;

    logic                       tready_c;
    logic                       beat_acc_c;
    site_e                      site_c;
    logic [RGB_TDATA_WIDTH-1:0] rgb_tdata_c;
    logic [RAW_PX_WIDTH-1:0]    px_c;
    logic                       unused_in_c;

    // Skid-free single stage: accept whenever the output slot is empty or draining
    assign tready_c             = !out_valid_q || raw_video_o.tready;
    assign rgb_video_i.tready   = tready_c;
    assign beat_acc_c           = rgb_video_i.tvalid && tready_c;
    assign rgb_tdata_c          = rgb_video_i.tdata;

    // Sideband fields carry no meaning for this block
    assign unused_in_c = ^{rgb_video_i.tkeep, rgb_video_i.tstrb,
                           rgb_video_i.tid, rgb_video_i.tdest, rgb_tdata_c};

    bayer_phase_tracker #(
        .MAX_LINE_SIZE (MAX_LINE_SIZE),
        .MAX_LINES     (MAX_LINES)
    ) u_phase (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .beat_acc_i          (beat_acc_c),
        .tuser_i             (rgb_video_i.tuser),
        .tlast_i             (rgb_video_i.tlast),
        .first_px_is_odd_i   (first_px_is_odd_i),
        .first_line_is_odd_i (first_line_is_odd_i),
        .clr_err_i           (clr_err_i),
        .site_c              (site_c),
        .line_len_o          (line_len_o),
        .frame_lines_o       (frame_lines_o),
        .err_line_len_o      (err_line_len_o),
        .err_sof_o           (err_sof_o)
    );

    // Component select for the current CFA site
    always_comb begin
        px_c = rgb_tdata_c[G_OFS +: RAW_PX_WIDTH];
        if (en_i) begin
            unique case (site_c)
                SITE_R:  px_c = rgb_tdata_c[R_OFS +: RAW_PX_WIDTH];
                SITE_B:  px_c = rgb_tdata_c[B_OFS +: RAW_PX_WIDTH];
                default: px_c = rgb_tdata_c[G_OFS +: RAW_PX_WIDTH];
            endcase
        end
    end

    // Output register; held while stalled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_user_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (beat_acc_c) begin
            out_valid_q <= 1'b1;
            out_last_q  <= rgb_video_i.tlast;
            out_user_q  <= rgb_video_i.tuser;
            out_data_q  <= RAW_TDATA_WIDTH'(px_c);
        end else if (raw_video_o.tready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign raw_video_o.tvalid = out_valid_q;
    assign raw_video_o.tlast  = out_last_q;
    assign raw_video_o.tuser  = out_user_q;
    assign raw_video_o.tdata  = out_data_q;
    assign raw_video_o.tkeep  = '1;
    assign raw_video_o.tstrb  = '1;
    assign raw_video_o.tid    = 1'b0;
    assign raw_video_o.tdest  = 1'b0;

endmodule

// File: tb/tb_bayer_mosaicing.sv
// Scoreboard bench for bayer_mosaicing: driver pushes expected raw beats on
// acceptance, monitor pops and compares on every output transfer.
module tb_bayer_mosaicing;

    typedef struct packed {
        logic        user;
        logic        last;
        logic [15:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        fpx = 1'b0;
    logic        fline = 1'b0;
    logic        clr = 1'b0;
    logic [10:0] line_len;
    logic [10:0] frame_lines;
    logic        err_line;
    logic        err_sof;

    int          rdy_mode = 0;   // 0 always ready, 1 random, 2 never ready
    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    logic [9:0]  t1_exp[8];
    logic [9:0]  t2_exp[8];

    axi4_stream_if #(.DATA_W(32)) rgb ();
    axi4_stream_if #(.DATA_W(16)) raw ();

    bayer_mosaicing #(
        .RAW_PX_WIDTH  (10),
        .MAX_LINE_SIZE (1920),
        .MAX_LINES     (1080)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .en_i                (en),
        .first_px_is_odd_i   (fpx),
        .first_line_is_odd_i (fline),
        .clr_err_i           (clr),
        .rgb_video_i         (rgb),
        .raw_video_o         (raw),
        .line_len_o          (line_len),
        .frame_lines_o       (frame_lines),
        .err_line_len_o      (err_line),
        .err_sof_o           (err_sof)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference site model: (line_odd, px_odd) 00->B, 11->R, else G; bypass -> G
    function automatic logic [9:0] model(input logic [9:0] r, g, b,
                                         input logic lo, po, e);
        if (!e) return g;
        case ({lo, po})
            2'b00:   return b;
            2'b11:   return r;
            default: return g;
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance with tvalid low
    task automatic send_beat(input logic [9:0] r, g, b, input logic u, l,
                             input logic [9:0] exp);
        int n = 0;
        rgb.tvalid = 1'b1;
        rgb.tdata  = {2'b00, r, b, g};
        rgb.tuser  = u;
        rgb.tlast  = l;
        #1;
        while (!rgb.tready) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 1000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: tready low for %0d cycles, expected high", n);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
        @(posedge clk);
        exp_q.push_back({u, l, 6'b0, exp});
        @(negedge clk);
        rgb.tvalid = 1'b0;
    endtask

    task automatic send_line(input int w, input logic lo, po0, sof, eol, e, gaps,
                             input int base);
        logic [9:0] r, g, b;
        logic       po;
        for (int x = 0; x < w; x++) begin
            if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
            r  = 10'(32'h200 + base * 17 + x);
            g  = 10'(base * 5 + x * 3);
            b  = 10'(32'h100 ^ (base + x * 7));
            po = po0 ^ x[0];
            send_beat(r, g, b, sof && (x == 0), eol && (x == w - 1), model(r, g, b, lo, po, e));
        end
    endtask

    task automatic send_frame(input int w, h, input logic po0, lo0, e, gaps);
        for (int y = 0; y < h; y++) begin
            send_line(w, lo0 ^ y[0], po0, y == 0, 1'b1, e, gaps, y);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // Downstream ready pattern
    initial begin
        raw.tready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       raw.tready = 1'b1;
                1:       raw.tready = 1'($urandom_range(0, 1));
                default: raw.tready = 1'b0;
            endcase
        end
    end

    // Monitor: compares each transfer and checks hold-while-stalled
    initial begin
        beat_t       e;
        logic        stall = 1'b0;
        logic [17:0] held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("stall_hold", {13'b0, raw.tvalid, raw.tuser, raw.tlast, raw.tdata},
                          {13'b0, 1'b1, held});
                end
                stall = raw.tvalid && !raw.tready;
                held  = {raw.tuser, raw.tlast, raw.tdata};
                if (raw.tvalid && raw.tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_beat", 32'({raw.tuser, raw.tlast, raw.tdata}), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        t1_exp = '{10'h0AA, 10'h155, 10'h0AA, 10'h155, 10'h155, 10'h3FF, 10'h155, 10'h3FF};
        t2_exp = '{10'h155, 10'h0AA, 10'h155, 10'h0AA, 10'h3FF, 10'h155, 10'h3FF, 10'h155};
        rgb.tvalid = 1'b0;
        rgb.tdata  = '0;
        rgb.tuser  = 1'b0;
        rgb.tlast  = 1'b0;
        rgb.tkeep  = '1;
        rgb.tstrb  = '1;
        rgb.tid    = 1'b0;
        rgb.tdest  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_tvalid", raw.tvalid, 0);
        check("rst_tdata", raw.tdata, 0);
        check("rst_sideband", {raw.tlast, raw.tuser}, 0);
        check("rst_status", {line_len, frame_lines}, 0);
        check("rst_flags", {err_line, err_sof}, 0);
        check("tkeep_tstrb", {raw.tkeep, raw.tstrb}, 4'hF);
        check("in_tready", rgb.tready, 1);

        // 4x2, even phases
        for (int i = 0; i < 8; i++)
            send_beat(10'h3FF, 10'h155, 10'h0AA, i == 0, i == 3 || i == 7, t1_exp[i]);
        drain();
        check("no_frame_len", line_len, 0);
        check("no_frame_lines", frame_lines, 0);

        // 4x2, odd first pixel
        fpx = 1'b1;
        for (int i = 0; i < 8; i++)
            send_beat(10'h3FF, 10'h155, 10'h0AA, i == 0, i == 3 || i == 7, t2_exp[i]);
        drain();
        check("frame1_len", line_len, 4);
        check("frame1_lines", frame_lines, 2);

        // 16x8 with input gaps and random backpressure
        fpx      = 1'b0;
        fline    = 1'b1;
        rdy_mode = 1;
        send_frame(16, 8, 1'b0, 1'b1, 1'b1, 1'b1);
        drain();
        rdy_mode = 0;

        // Bypass: G everywhere
        en    = 1'b0;
        fline = 1'b0;
        for (int i = 0; i < 8; i++)
            send_beat(10'h3FF, 10'h155, 10'h0AA, i == 0, i == 3 || i == 7, 10'h155);
        drain();
        check("frame16_len", line_len, 16);
        check("frame16_lines", frame_lines, 8);
        check("no_err_yet", {err_line, err_sof}, 0);
        en = 1'b1;

        // Line lengths 4,4,3
        send_line(4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        send_line(4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        check("len_ok_line2", err_line, 0);
        send_line(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        check("len_err_line3", err_line, 1);
        check("sof_clean", err_sof, 0);

        // tuser on the second beat of a line
        send_line(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        send_line(4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4);
        check("sof_err", err_sof, 1);
        check("short_frame_lines", frame_lines, 3);
        check("short_frame_len", line_len, 4);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_flags", {err_line, err_sof}, 0);

        // Error event in the same cycle as clear: error wins
        send_line(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
        clr = 1'b1;
        send_line(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6);
        clr = 1'b0;
        check("err_beats_clr", err_sof, 1);
        check("clr_line_flag", err_line, 0);
        drain();

        // Reset mid-line with the output stalled
        rdy_mode = 2;
        @(negedge clk);
        rgb.tvalid = 1'b1;
        rgb.tdata  = {2'b00, 10'h3FF, 10'h0AA, 10'h155};
        rgb.tuser  = 1'b1;
        rgb.tlast  = 1'b0;
        #1;
        check("ready_empty", rgb.tready, 1);
        @(posedge clk);
        @(negedge clk);
        rgb.tuser = 1'b0;
        rst       = 1'b1;
        #1;
        check("ready_stalled", rgb.tready, 0);
        @(negedge clk);
        rst        = 1'b0;
        rgb.tvalid = 1'b0;
        #2;
        check("post_rst_tvalid", raw.tvalid, 0);
        check("post_rst_flags", {err_line, err_sof}, 0);
        check("post_rst_status", {line_len, frame_lines}, 0);
        rdy_mode = 0;
        @(negedge clk);

        // First frame after reset
        send_frame(4, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        send_line(4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        drain();
        check("post_rst_len", line_len, 4);
        check("post_rst_lines", frame_lines, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
